// File: rtl/sha256_chunk_engine.sv
// sha256_chunk_engine: folded SHA-256 compression, UNROLL rounds per clock, internal chaining hash; optional SHA224_MODE_EN adds SHA-224 IV/truncation
module sha256_chunk_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_chunk,
    input  logic         in_first,
    input  logic         in_last,
`ifdef SHA224_MODE_EN
    input  logic         in_mode_224,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_hash,
    output logic         busy
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
        $error("sha256_chunk_engine: UNROLL must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [0:7][31:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    state_t            state_q, state_d;
    logic [0:7][31:0]  h_q, h_d, work_q, work_d, st, iv_new, iv_cur;
    logic [0:15][31:0] w_q, w_d, wk;
    logic [5:0]        t_q, t_d;
    logic              last_q, last_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

`ifdef SHA224_MODE_EN
    localparam logic [0:7][31:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    logic mode_q, mode_d;
    assign iv_new   = in_mode_224 ? IV224 : IV256;
    assign iv_cur   = mode_q ? IV224 : IV256;
    assign out_hash = {h_q[0:6], (mode_q && out_valid_q) ? 32'h0 : h_q[7]};
`else
    assign iv_new   = IV256;
    assign iv_cur   = IV256;
    assign out_hash = h_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // chain UNROLL rounds from the working registers, sliding the 16-word schedule window one word per round
    always_comb begin
        logic [31:0] t1, t2;
        t1 = '0;
        t2 = '0;
        st = work_q;
        wk = w_q;
        for (int r = 0; r < UNROLL; r++) begin
            t1 = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[t_q + 6'(r)] + wk[0];
            t2 = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
            st = {t1 + t2, st[0], st[1], st[2], st[3] + t1, st[4], st[5], st[6]};
            wk = {wk[1:15], ssig1(wk[14]) + wk[9] + ssig0(wk[1]) + wk[0]};
        end
    end

    // next-state and registered handshake outputs for IDLE -> RUN -> (IDLE | DONE)
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        work_d      = work_q;
        w_d         = w_q;
        t_d         = t_q;
        last_d      = last_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SHA224_MODE_EN
        mode_d      = (state_q == IDLE && in_valid && in_first) ? in_mode_224 : mode_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                h_d        = in_first ? iv_new : h_q;
                work_d     = in_first ? iv_new : h_q;
                w_d        = in_chunk;
                last_d     = in_last;
                t_d        = '0;
                state_d    = RUN;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
            RUN: begin
                work_d = st;
                w_d    = wk;
                t_d    = t_q + 6'(UNROLL);
                if (t_q == 6'(64 - UNROLL)) begin
                    for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + st[i];
                    state_d     = last_q ? DONE : IDLE;
                    out_valid_d = last_q;
                    in_ready_d  = !last_q;
                    busy_d      = last_q;
                end
            end
            DONE: if (out_ready) begin
                h_d         = iv_cur;
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any chunk in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_q         <= IV256;
            work_q      <= '0;
            w_q         <= '0;
            t_q         <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHA224_MODE_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            work_q      <= work_d;
            w_q         <= w_d;
            t_q         <= t_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SHA224_MODE_EN
            mode_q      <= mode_d;
`endif
        end
    end
endmodule

// File: tb/tb_sha256_chunk_engine.sv
// tb_sha256_chunk_engine: directed known-answer vectors for the SHA-256 chunk engine (UNROLL=1 and UNROLL=4)
module tb_sha256_chunk_engine;
    localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_EMP  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] C_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] C_EMP  = {32'h80000000, 480'h0};
    localparam logic [511:0] C_M1   = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                       192'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                       32'h80000000, 32'h00000000};
    localparam logic [511:0] C_M2   = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_valid4 = 1'b0;
    logic [511:0] in_chunk = '0;
    logic         in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
    logic [255:0] out_hash, out_hash4;
`ifdef SHA224_MODE_EN
    logic         mode224 = 1'b0;
`endif
    int           n_vec = 0, n_bad = 0, cyc;

    always #5 clk = ~clk;

    sha256_chunk_engine #(.UNROLL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_chunk(in_chunk),
        .in_first(in_first), .in_last(in_last),
`ifdef SHA224_MODE_EN
        .in_mode_224(mode224),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash), .busy(busy));

    sha256_chunk_engine #(.UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_chunk(in_chunk),
        .in_first(in_first), .in_last(in_last),
`ifdef SHA224_MODE_EN
        .in_mode_224(1'b0),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .out_hash(out_hash4), .busy(busy4));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [511:0] c, input logic f, input logic l);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        in_chunk = c;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_chunk = ~c;
        in_first = ~f;
        in_last  = ~l;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hash", out_hash, IV);

        offer(C_ABC, 1, 1);
        chk("abc_busy", busy, 1);
        chk("abc_ready", in_ready, 0);
        wait_out(cyc);
        chk("abc_latency", cyc, 64);
        chk("abc_hash", out_hash, H_ABC);
        take();
        chk("hs_valid", out_valid, 0);
        chk("hs_ready", in_ready, 1);
        chk("hs_iv", out_hash, IV);

        offer(C_EMP, 1, 1);
        wait_out(cyc);
        chk("empty_hash", out_hash, H_EMP);
        take();

        offer(C_M1, 1, 0);
        chk("two_run1_ready", in_ready, 0);
        wait_ready(cyc);
        chk("two_gap_latency", cyc, 64);
        chk("two_gap_valid", out_valid, 0);
        offer(C_M2, 0, 1);
        chk("two_run2_ready", in_ready, 0);
        wait_out(cyc);
        chk("two_hash", out_hash, H_TWO);
        take();

        offer(C_ABC, 1, 1);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_hash", out_hash, H_ABC);
            chk("bp_ready", in_ready, 0);
        end
        take();
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_ready", in_ready, 1);
        offer(C_ABC, 0, 1);
        wait_out(cyc);
        chk("bp_rechain_hash", out_hash, H_ABC);
        take();

        offer(C_M1, 1, 0);
        wait_ready(cyc);
        offer(C_ABC, 1, 1);
        wait_out(cyc);
        chk("restart_hash", out_hash, H_ABC);
        take();

        offer(C_ABC, 1, 1);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hash", out_hash, IV);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        offer(C_ABC, 0, 1);
        wait_out(cyc);
        chk("post_rst_latency", cyc, 64);
        chk("post_rst_hash", out_hash, H_ABC);
        take();

        in_chunk  = C_ABC;
        in_first  = 1'b1;
        in_last   = 1'b1;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        in_chunk  = '0;
        chk("u4_busy", busy4, 1);
        chk("u4_ready", in_ready4, 0);
        cyc = 0;
        while (!out_valid4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("u4_latency", cyc, 16);
        chk("u4_hash", out_hash4, H_ABC);
        take();
        chk("u4_hs_valid", out_valid4, 0);

`ifdef SHA224_MODE_EN
        mode224 = 1'b1;
        offer(C_ABC, 1, 1);
        mode224 = 1'b0;
        wait_out(cyc);
        chk("sha224_hash", out_hash, 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
        take();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_chunk_engine.md
Name: sha256_chunk_engine

Overview:
Parametrised, folded SHA-256 compression engine. It performs UNROLL rounds per clock, so one 512-bit chunk takes 64/UNROLL cycles. It keeps the chaining hash internally, so multi-chunk messages are processed back-to-back. Ready/valid handshakes on input and output let it sit between the padding/framing stage and the digest consumer, trading area against throughput.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4, 8, 16; any other value raises an elaboration $error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  chunk offered
in_ready  output  1  engine can accept a chunk
in_chunk  input  512  message chunk; word W0 in bits [511:480], W15 in [31:0]
in_first  input  1  chunk starts a new message (chaining reset to IV)
in_last  input  1  chunk ends the message (digest produced)
out_valid  output  1  digest available
out_ready  input  1  consumer accepts digest
out_hash  output  256  H0 in [255:224] ... H7 in [31:0]
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on the rising edge of clk.
- Reset: state=IDLE, chaining H=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), round counter=0, in_ready=1, out_valid=0, busy=0, out_hash=IV.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0): if in_first, H<=IV first; working regs a..h<=H (or IV if in_first); 16-word schedule window<=in_chunk; last flag latched; t<=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge performs UNROLL chained rounds t..t+UNROLL-1 using K[t] and W[t].
  - W[t] for t>=16 comes from the sliding window: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], all mod 2^32.
  - t+=UNROLL.
- RUN termination, at the edge completing round 63 (edge E(64/UNROLL)):
  - H<=H+{a..h}, word-wise mod 2^32.
  - If last: go to DONE.
  - Else: go to IDLE, keeping H for the next chunk.
- Latency: out_valid rises exactly 64/UNROLL edges after E0 (64 for UNROLL=1).
- State DONE:
  - out_valid=1; out_hash=H, stable while out_ready=0; in_ready=0.
  - On out_valid&&out_ready: H<=IV, go to IDLE.
  - in_ready returns high the cycle after the handshake; there is no same-cycle accept.
- out_hash always reflects register H. It is valid only while out_valid=1.
- Chunk arriving with in_first=0:
  - After reset or a completed message: chains from IV.
  - Mid-message: chains from the stored H.
- in_first=1 arriving mid-message: the partial hash is discarded and the chunk starts a new message.
- in_first=in_last=1: single-chunk message.
- in_valid while in_ready=0: ignored; the source must hold the chunk.
- in_chunk/in_first/in_last are sampled only at the accept edge.
- Reset asserted in any state: immediate return to reset values. An in-flight chunk is lost and no partial out_valid is produced.
- Round constants K[0..63]: the standard SHA-256 table in a localparam.
- All additions are 32-bit and wrap modulo 2^32.

Optional Feature:
SHA224_MODE_EN
- Defined:
  - Adds input port in_mode_224 (1 bit), sampled only when in_first=1 and latched per message.
  - When set: chaining init, and the reload after the output handshake, use the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - When set: out_hash[31:0] is forced to 0 while out_valid.
- Undefined: the port is absent and the engine is SHA-256 only.

Test Plan:
- "abc" single chunk (61626380, 14 zero words, 00000018), first=last=1, UNROLL=1 -> out_valid exactly 64 edges after accept; out_hash=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (80000000 then zeros), first=last=1 -> out_hash=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-chunk "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second chunk carries 80000000, zeros, length 000001c0) -> in_ready low during each RUN and high between chunks; out_hash=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_hash stable, in_ready=0. Then out_ready=1 -> one handshake, in_ready=1 next cycle, and the next "abc" chunk with in_first=0 still yields the ba7816bf... digest.
- Reset mid-run: drop rst_n at round 30 of an "abc" chunk -> out_valid=0, in_ready=1, out_hash=IV immediately; rerun "abc" -> correct digest.
- UNROLL=4 build with "abc" -> out_valid 16 edges after accept, same digest. With SHA224_MODE_EN and in_mode_224=1 -> out_hash=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
